// File: rtl/tx_bert.sv
// tx_bert: transmit-side BERT pattern source.
//
// Produces one DataWidth-bit word per enabled cycle for the serializer:
// multi-bit PRBS (7/15/23/31), a fixed word, an alternating clock pattern,
// or all-zeros. Bit 0 of o_data_out is the earliest bit on the wire.
//
// Optional build macro: TX_BERT_ERR_INJ_EN
//   defined     - periodic error injection (counter, mask XOR, o_err_inj_count)
//   not defined - no injection hardware, o_err_inj_count tied to 0,
//                 period and mask inputs ignored
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_en                    clock enable, all state holds when low
//   i_cfg_tx_mode           0 zeros, 1 PRBS, 2 fixed word, 3 clock pattern
//   i_cfg_prbs_load_en/_in  LFSR load request (level) and seed
//   i_cfg_prbs_run_en       run request (level)
//   i_cfg_prbs_out_inv      invert PRBS bits
//   i_cfg_tx_pattern        fixed word for mode 2
//   i_cfg_err_inj_period    inject once every N RUN cycles, 0 disables
//   i_cfg_err_inj_mask      bits flipped in an injected word
//   o_data_out, o_running   registered word and RUN indicator
//   o_err_inj_count         injected words (saturating)
//   o_bit_count             bits sent in RUN (saturating)
//
// state | meaning
// IDLE  | reset state, output zeros, LFSR holds
// LOAD  | LFSR takes the seed (all-ones if seed is zero) every cycle
// RUN   | LFSR advances DataWidth steps per cycle, pattern words emitted
module tx_bert #(
  parameter int DataWidth      = 8,
  parameter int PRBSLength     = 31,
  parameter int ErrPeriodWidth = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [1:0]                i_cfg_tx_mode,
  input  logic                      i_cfg_prbs_load_en,
  input  logic [PRBSLength-1:0]     i_cfg_prbs_load_in,
  input  logic                      i_cfg_prbs_run_en,
  input  logic                      i_cfg_prbs_out_inv,
  input  logic [DataWidth-1:0]      i_cfg_tx_pattern,
  input  logic [ErrPeriodWidth-1:0] i_cfg_err_inj_period,
  input  logic [DataWidth-1:0]      i_cfg_err_inj_mask,
  output logic [DataWidth-1:0]      o_data_out,
  output logic                      o_running,
  output logic [31:0]               o_err_inj_count,
  output logic [40:0]               o_bit_count
);

  // Second feedback tap for the supported polynomials.
  localparam int Tap = (PRBSLength == 7)  ? 6  :
                       (PRBSLength == 15) ? 14 :
                       (PRBSLength == 23) ? 18 : 28;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state_q, state_d;
  logic [PRBSLength-1:0]   lfsr_q, lfsr_adv, prbs_s;
  logic                    prbs_b;
  logic [DataWidth-1:0]    prbs_word, pre_word, word_d, data_q;
  logic                    phase_q;
  logic                    running_q;
  logic [40:0]             bit_cnt_q;
  logic [41:0]             bit_sum;
  logic                    in_run;

  assign in_run = (state_q == RUN);

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; load_en wins over run_en everywhere
  always_comb begin
    state_d = state_q;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (i_cfg_prbs_load_en)     state_d = LOAD;
          else if (i_cfg_prbs_run_en) state_d = RUN;
        end
        LOAD: begin
          if (!i_cfg_prbs_load_en) state_d = i_cfg_prbs_run_en ? RUN : IDLE;
        end
        RUN: begin
          if (i_cfg_prbs_load_en)      state_d = LOAD;
          else if (!i_cfg_prbs_run_en) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Unrolled serial LFSR: the k-th serial bit lands in word bit k.
  always_comb begin
    prbs_s    = lfsr_q;
    prbs_b    = 1'b0;
    prbs_word = '0;
    for (int k = 0; k < DataWidth; k++) begin
      prbs_b       = prbs_s[PRBSLength-1] ^ prbs_s[Tap-1];
      prbs_word[k] = prbs_b;
      prbs_s       = {prbs_s[PRBSLength-2:0], prbs_b};
    end
    lfsr_adv = prbs_s;
  end

  always_comb begin
    case (i_cfg_tx_mode)
      2'd0:    pre_word = '0;
      2'd1:    pre_word = prbs_word ^ {DataWidth{i_cfg_prbs_out_inv}};
      2'd2:    pre_word = i_cfg_tx_pattern;
      default: pre_word = phase_q ? '0 : '1;
    endcase
  end

`ifdef TX_BERT_ERR_INJ_EN
  logic [ErrPeriodWidth-1:0] err_cnt_q;
  logic [31:0]               inj_cnt_q;
  logic                      inj_hit;

  assign inj_hit = in_run && (i_cfg_err_inj_period != '0) &&
                   (err_cnt_q == i_cfg_err_inj_period - ErrPeriodWidth'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt_q <= '0;
      inj_cnt_q <= '0;
    end else if (i_en) begin
      if (!in_run || (i_cfg_err_inj_period == '0) || inj_hit) err_cnt_q <= '0;
      else                                                     err_cnt_q <= err_cnt_q + ErrPeriodWidth'(1);
      if (inj_hit && (inj_cnt_q != '1)) inj_cnt_q <= inj_cnt_q + 32'd1;
    end
  end

  assign word_d          = in_run ? (pre_word ^ (inj_hit ? i_cfg_err_inj_mask : '0)) : '0;
  assign o_err_inj_count = inj_cnt_q;
`else
  logic unused_err_cfg;
  assign unused_err_cfg  = ^{i_cfg_err_inj_period, i_cfg_err_inj_mask};
  assign word_d          = in_run ? pre_word : '0;
  assign o_err_inj_count = '0;
`endif

  assign bit_sum = {1'b0, bit_cnt_q} + 42'(DataWidth);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q    <= '1;
      data_q    <= '0;
      running_q <= 1'b0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else if (i_en) begin
      data_q    <= word_d;
      running_q <= in_run;
      // clock pattern restarts with the ones word on every RUN entry
      phase_q   <= in_run ? ~phase_q : 1'b0;
      case (state_q)
        LOAD:    lfsr_q <= (i_cfg_prbs_load_in == '0) ? '1 : i_cfg_prbs_load_in;
        RUN:     lfsr_q <= lfsr_adv;
        default: lfsr_q <= lfsr_q;
      endcase
      if (in_run) bit_cnt_q <= bit_sum[41] ? '1 : bit_sum[40:0];
    end
  end

  assign o_data_out  = data_q;
  assign o_running   = running_q;
  assign o_bit_count = bit_cnt_q;

endmodule

// File: tb/tb_tx_bert.sv
module tb_tx_bert;
  localparam int DW  = 8;
  localparam int L   = 7;
  localparam int T   = 6;
  localparam int EPW = 16;
`ifdef TX_BERT_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif
  localparam longint BitMax = (64'd1 << 41) - 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic           i_clk, i_rst, i_en;
  logic [1:0]     i_cfg_tx_mode;
  logic           i_cfg_prbs_load_en, i_cfg_prbs_run_en, i_cfg_prbs_out_inv;
  logic [L-1:0]   i_cfg_prbs_load_in;
  logic [DW-1:0]  i_cfg_tx_pattern, i_cfg_err_inj_mask;
  logic [EPW-1:0] i_cfg_err_inj_period;
  logic [DW-1:0]  o_data_out;
  logic           o_running;
  logic [31:0]    o_err_inj_count;
  logic [40:0]    o_bit_count;

  tx_bert #(.DataWidth(DW), .PRBSLength(L), .ErrPeriodWidth(EPW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .i_cfg_tx_mode(i_cfg_tx_mode),
    .i_cfg_prbs_load_en(i_cfg_prbs_load_en),
    .i_cfg_prbs_load_in(i_cfg_prbs_load_in),
    .i_cfg_prbs_run_en(i_cfg_prbs_run_en),
    .i_cfg_prbs_out_inv(i_cfg_prbs_out_inv),
    .i_cfg_tx_pattern(i_cfg_tx_pattern),
    .i_cfg_err_inj_period(i_cfg_err_inj_period),
    .i_cfg_err_inj_mask(i_cfg_err_inj_mask),
    .o_data_out(o_data_out), .o_running(o_running),
    .o_err_inj_count(o_err_inj_count), .o_bit_count(o_bit_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: PRBS as the bit recurrence x[n] = x[n-L] ^ x[n-T]
  // over a history window (hist[0] is the oldest bit).
  bit           hist[$];
  int           m_state;
  logic [DW-1:0] m_data;
  bit           m_running;
  logic [31:0]  m_inj;
  longint       m_bits;
  int           m_since;
  int           m_run_cycles;

  function automatic void model_seed(input logic [L-1:0] seed);
    logic [L-1:0] sd;
    sd = (seed == '0) ? '1 : seed;
    hist.delete();
    for (int j = L - 1; j >= 0; j--) hist.push_back(sd[j]);
  endfunction

  function automatic bit next_bit();
    bit b;
    b = hist[0] ^ hist[L-T];
    hist.push_back(b);
    void'(hist.pop_front());
    return b;
  endfunction

  function automatic void model_reset();
    model_seed('0);
    m_state = M_IDLE; m_data = '0; m_running = 0; m_inj = '0;
    m_bits = 0; m_since = 0; m_run_cycles = 0;
  endfunction

  function automatic void model_step();
    int            nxt;
    logic [DW-1:0] w, pre;
    bit            inj;
    if (!i_en) return;
    if (i_cfg_prbs_load_en)     nxt = M_LOAD;
    else if (i_cfg_prbs_run_en) nxt = M_RUN;
    else                        nxt = M_IDLE;
    if (m_state == M_RUN) begin
      w = '0;
      for (int k = 0; k < DW; k++) w[k] = next_bit();
      case (i_cfg_tx_mode)
        2'd0:    pre = '0;
        2'd1:    pre = i_cfg_prbs_out_inv ? ~w : w;
        2'd2:    pre = i_cfg_tx_pattern;
        default: pre = (m_run_cycles % 2 == 0) ? '1 : '0;
      endcase
      m_run_cycles++;
      inj = 0;
      if (INJ && i_cfg_err_inj_period != 0) begin
        m_since++;
        if (m_since == int'(i_cfg_err_inj_period)) begin
          inj = 1; m_since = 0;
          if (m_inj != 32'hFFFF_FFFF) m_inj++;
        end
      end else m_since = 0;
      m_data    = inj ? (pre ^ i_cfg_err_inj_mask) : pre;
      m_running = 1;
      m_bits    = (m_bits + DW > BitMax) ? BitMax : m_bits + DW;
    end else begin
      m_data = '0; m_running = 0; m_run_cycles = 0; m_since = 0;
      if (m_state == M_LOAD) model_seed(i_cfg_prbs_load_in);
    end
    m_state = nxt;
  endfunction

  task automatic check_outputs();
    chk("data", o_data_out, m_data);
    chk("running", o_running, m_running);
    chk("inj_count", o_err_inj_count, m_inj);
    chk("bit_count", o_bit_count, m_bits);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    model_reset();
    check_outputs();
    i_rst = 1'b0;
  endtask

  task automatic en_tick(input bit half);
    if (half) begin
      i_en = 1'b0; tick(); i_en = 1'b1;
    end
    tick();
  endtask

  logic [DW-1:0] cap[16];
  logic [DW-1:0] ref_w[16];

  task automatic capture(input bit half);
    do_reset();
    i_cfg_prbs_load_in = 7'h7F; i_cfg_tx_mode = 2'd1; i_cfg_prbs_out_inv = 0;
    i_cfg_err_inj_period = '0;
    i_cfg_prbs_load_en = 1; i_cfg_prbs_run_en = 0; en_tick(half);
    i_cfg_prbs_load_en = 0; i_cfg_prbs_run_en = 1; en_tick(half);
    for (int i = 0; i < 16; i++) begin
      en_tick(half);
      cap[i] = o_data_out;
    end
    i_cfg_prbs_run_en = 0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_cfg_tx_mode = 2'd1;
    i_cfg_prbs_load_en = 0; i_cfg_prbs_run_en = 0; i_cfg_prbs_out_inv = 0;
    i_cfg_prbs_load_in = 7'h7F; i_cfg_tx_pattern = '0;
    i_cfg_err_inj_period = '0; i_cfg_err_inj_mask = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs();
    i_rst = 1'b0;

    // PRBS7 from seed 7F
    i_cfg_prbs_load_en = 1; tick();
    i_cfg_prbs_load_en = 0; i_cfg_prbs_run_en = 1; tick();
    tick();
    chk("prbs7_first", o_data_out, 8'h40);
    repeat (999) tick();
    chk("bit_count_1000", o_bit_count, 8000);

    // zero seed, plain then inverted
    i_cfg_prbs_run_en = 0; tick(); tick();
    i_cfg_prbs_load_in = '0; i_cfg_prbs_load_en = 1; tick();
    i_cfg_prbs_load_en = 0; i_cfg_prbs_run_en = 1; tick(); tick();
    chk("zero_seed_word", o_data_out, 8'h40);
    chk("zero_seed_nonzero", (o_data_out != '0), 1);
    repeat (20) tick();
    i_cfg_prbs_run_en = 0; tick(); tick();
    i_cfg_prbs_out_inv = 1; i_cfg_prbs_load_en = 1; tick();
    i_cfg_prbs_load_en = 0; i_cfg_prbs_run_en = 1; tick(); tick();
    chk("inv_first", o_data_out, 8'hBF);
    repeat (30) tick();
    i_cfg_prbs_out_inv = 0;

    // fixed word then clock pattern
    i_cfg_prbs_run_en = 0; tick(); tick();
    i_cfg_tx_mode = 2'd2; i_cfg_tx_pattern = 8'hA5; i_cfg_prbs_run_en = 1; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mode2_word", o_data_out, 8'hA5);
    end
    i_cfg_prbs_run_en = 0; tick(); tick();
    chk("stop_data", o_data_out, 8'h00);
    chk("stop_running", o_running, 0);
    i_cfg_tx_mode = 2'd3; i_cfg_prbs_run_en = 1; tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mode3_word", o_data_out, (i % 2 == 0) ? 8'hFF : 8'h00);
    end

    // error injection, period 4 mask 01 in mode 0
    i_cfg_prbs_run_en = 0; tick(); tick();
    i_cfg_tx_mode = 2'd0; i_cfg_err_inj_period = 4; i_cfg_err_inj_mask = 8'h01;
    i_cfg_prbs_run_en = 1; tick();
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("inj_word", o_data_out, (INJ && (i % 4 == 0)) ? 8'h01 : 8'h00);
    end
    chk("inj_count_20", o_err_inj_count, INJ ? 5 : 0);
    i_cfg_prbs_run_en = 0; tick(); tick();
    i_cfg_err_inj_period = 0; i_cfg_prbs_run_en = 1;
    repeat (12) tick();
    i_cfg_prbs_run_en = 0; tick(); tick();
    i_cfg_err_inj_period = 4; i_cfg_err_inj_mask = 8'hFF; i_cfg_prbs_run_en = 1;
    repeat (9) tick();
    chk("inj_count_ff", o_err_inj_count, INJ ? 7 : 0);
    i_cfg_prbs_run_en = 0; tick();

    // half-rate enable must reproduce the full-rate stream
    capture(1'b0);
    for (int i = 0; i < 16; i++) ref_w[i] = cap[i];
    capture(1'b1);
    for (int i = 0; i < 16; i++) chk("half_rate", cap[i], ref_w[i]);

    // asynchronous reset in the middle of RUN
    i_cfg_prbs_run_en = 1; tick(); tick(); tick();
    #3 i_rst = 1'b1;
    #1;
    chk("rst_async_data", o_data_out, 0);
    chk("rst_async_running", o_running, 0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_cfg_prbs_run_en = 0; tick();
    i_cfg_prbs_run_en = 1; tick(); tick();
    chk("rst_first_word", o_data_out, 8'h40);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      i_en = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      if (r < 3) i_cfg_prbs_run_en = ~i_cfg_prbs_run_en;
      i_cfg_prbs_load_en = (r >= 96);
      if ($urandom_range(0, 49) == 0) i_cfg_tx_mode = 2'($urandom_range(0, 3));
      if (m_state == M_IDLE && $urandom_range(0, 3) == 0) begin
        i_cfg_prbs_load_in   = 7'($urandom_range(0, 127));
        i_cfg_prbs_out_inv   = 1'($urandom_range(0, 1));
        i_cfg_tx_pattern     = 8'($urandom);
        i_cfg_err_inj_period = 16'($urandom_range(0, 6));
        i_cfg_err_inj_mask   = 8'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_bert.md
# tx_bert

Transmit-side BERT pattern source that produces one `DataWidth`-bit word per cycle for the serializer. It generates a multi-bit PRBS (7/15/23/31), a fixed word, an alternating clock pattern, or all-zeros, and can inject deterministic bit errors so the receive-side BERT error count can be checked end to end. Bit ordering is LSB->MSB: `o_data_out[0]` is the earliest bit on the wire.

## Interface
- `DataWidth`, 8, bits per output word (1..64).
- `PRBSLength`, 31, LFSR length; legal values are 7, 15, 23, 31.
- `ErrPeriodWidth`, 16, width of the error-injection period.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_en`  in  1  clock enable; all state holds when low.
- `i_cfg_tx_mode`  in  2  pattern select: 0 zeros, 1 PRBS, 2 fixed word, 3 clock pattern.
- `i_cfg_prbs_load_en`  in  1  level; loads the LFSR from `i_cfg_prbs_load_in`.
- `i_cfg_prbs_load_in`  in  `PRBSLength`  LFSR seed.
- `i_cfg_prbs_run_en`  in  1  level; advances the LFSR.
- `i_cfg_prbs_out_inv`  in  1  inverts PRBS output bits.
- `i_cfg_tx_pattern`  in  `DataWidth`  fixed word used in mode 2.
- `i_cfg_err_inj_period`  in  `ErrPeriodWidth`  inject once every N running cycles; 0 disables injection.
- `i_cfg_err_inj_mask`  in  `DataWidth`  bits flipped in an injected word.
- `o_data_out`  out  `DataWidth`  registered pattern word.
- `o_running`  out  1  high in the RUN state.
- `o_err_inj_count`  out  32  number of injected words; saturates.
- `o_bit_count`  out  41  number of bits sent in RUN; saturates.

## Operation
- FSM states:
  - IDLE (reset state).
  - LOAD: entered when `i_cfg_prbs_load_en`=1.
    - Writes the seed into the LFSR; a zero seed writes all-ones instead.
    - Stays in LOAD while `load_en` is high.
  - RUN: entered from IDLE or LOAD when `load_en`=0 and `run_en`=1.
  - RUN -> IDLE when `run_en`=0. RUN -> LOAD when `load_en`=1; `load_en` has priority over `run_en`.
- Every transition requires `i_en`=1.
- LFSR, serial model: `b = s[L-1] ^ s[T-1]`, then `s <= {s[L-2:0], b}`. The taps (L,T) are (7,6), (15,14), (23,18), (31,28).
- Each RUN cycle advances the LFSR `DataWidth` serial steps. The k-th generated bit maps to `out[k]`.
- Pre-register word by mode:
  - mode 0: zeros.
  - mode 1: PRBS bits, XOR all-ones if `out_inv`.
  - mode 2: `i_cfg_tx_pattern`.
  - mode 3: alternating all-ones / all-zeros words, starting with ones on RUN entry.
- Outside RUN the word is zeros.
- Error injection (RUN only):
  - A cycle counter counts RUN cycles.
  - When the counter reaches `period-1`, that cycle's word is XORed with `i_cfg_err_inj_mask`, `o_err_inj_count` increments and the counter clears.
  - The counter clears on leaving RUN and whenever `period`=0.
- `o_bit_count` adds `DataWidth` per RUN cycle with `i_en`=1.
- Both counters saturate at all-ones and clear only on reset.
- A mode change mid-RUN does not disturb the LFSR: the LFSR advances in RUN regardless of mode.

## Timing
- Reset values: `o_data_out`=0, `o_running`=0, `o_err_inj_count`=0, `o_bit_count`=0, LFSR=all-ones, FSM=IDLE.
- Output latency:
  - `o_data_out` is registered, one cycle after the FSM and LFSR update.
  - The first PRBS word appears on the cycle after the first RUN cycle.
- `o_running` is registered together with `o_data_out`.
- Config inputs are quasi-static except `load_en` and `run_en`, which are sampled every enabled cycle.
- `i_en` low: outputs, counters, LFSR and FSM all hold.
- Reset asserted mid-RUN: all state returns to reset values at once; no partial word is emitted.

## Configuration
- `TX_BERT_ERR_INJ_EN` defined: error injection logic, counter and `o_err_inj_count` are present as described.
- Not defined:
  - No injection hardware.
  - `o_err_inj_count` ties to 0; period and mask inputs are ignored.
  - The data path is otherwise identical.

## Test plan
- PRBS7 with `DataWidth`=8, seed 7'h7F, load then run, mode 1:
  - First word is 8'h40.
  - The stream matches a bit-serial LFSR model for 1000 words.
  - `o_bit_count`=8000 after 1000 RUN cycles.
- Zero seed loaded: LFSR holds all-ones and PRBS output is nonzero. Repeat with `out_inv`=1: every output word is inverted.
- Mode 2 with pattern 8'hA5, then mode 3:
  - Mode 2 outputs 8'hA5 each cycle.
  - Mode 3 outputs FF,00,FF,... starting on RUN entry.
  - `run_en`=0 gives 8'h00 and `o_running`=0.
- Injection, period 4, mask 8'h01, mode 0, 20 RUN cycles: words 4, 8, 12, 16 and 20 are 8'h01; `o_err_inj_count`=5. Period 0: no injection.
- `i_en` toggled every other cycle: output sequence equals the `i_en`=1 sequence at half rate. Reset asserted mid-RUN: outputs are 0 immediately and the FSM is IDLE.
- Build without `TX_BERT_ERR_INJ_EN`, period 4, mask 8'hFF: no words corrupted and `o_err_inj_count`=0.
